// File: rtl/bus_fsm_pkg.sv
// Shared types and helpers for the bus arbitration FSM family.
package bus_fsm_pkg;

    // Same encoding as the original single-master bus FSM.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        WAIT = 2'b10,
        FREE = 2'b11
    } state_t;

    // Width needed to index/count v values, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/bus_arb_fsm_if.sv
// Handshake/bus bundle between bus masters and the arbiter.
interface bus_arb_fsm_if
    import bus_fsm_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = clog2_min1(NREQ)
);
    logic [NREQ-1:0] req;
    logic            done;
    logic            dly;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            busy;
    logic            timeout;

    // Arbiter side.
    modport slave (
        input  req, done, dly,
        output gnt, gnt_id, busy, timeout
    );

    // Requester side.
    modport master (
        output req, done, dly,
        input  gnt, gnt_id, busy, timeout
    );
endinterface

// File: rtl/bus_arb_fsm_rr_pick.sv
// Round-robin picker: first set request after 'last', wrapping, so the
// previous winner gets the lowest priority.
module rr_pick
    import bus_fsm_pkg::*;
#(
    parameter int N = 4,
    localparam int IDW = clog2_min1(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [IDW-1:0] idx,
    output logic           valid
);
    logic [IDW-1:0] cand;

    // Scan offsets 1..N from last; the first hit wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IDW'((32'(last) + i) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/bus_arb_fsm.sv
// Round-robin arbiter for one shared bus with BUSY/WAIT/FREE handshake and
// a hold-time watchdog. gnt_id drives the downstream bus mux select.
module bus_arb_fsm
    import bus_fsm_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int MAX_HOLD = 64,
    localparam int IDW = clog2_min1(NREQ),
    localparam int CW = clog2_min1(MAX_HOLD + 1)
) (
    input logic          clk,
    input logic          rst_n,
    bus_arb_fsm_if.slave bus
);
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

    state_t          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [CW-1:0]   hold_q, hold_d, hold_inc;
    logic            timeout_q, timeout_d;
    logic            wd_hit;
    logic [IDW-1:0]  pick_idx;
    logic            pick_valid;
    logic            tenure;
    logic [NREQ-1:0] gnt_d;

    rr_pick #(.N(NREQ)) u_pick (
        .req   (bus.req),
        .last  (owner_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Hold counter saturates instead of wrapping.
    assign hold_inc = (hold_q == '1) ? hold_q : hold_q + 1'b1;
    assign wd_hit   = (MAX_HOLD > 0) && (hold_q == HOLD_LAST);

    // State, owner, hold counter and timeout pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= IDW'(NREQ - 1);
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic; normal exits take precedence over the watchdog.
    // hold_cnt advances on every cycle spent in BUSY/WAIT (including the
    // BUSY->WAIT step) so the watchdog bounds total tenure to MAX_HOLD.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE, FREE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    owner_d = pick_idx;
                    hold_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (bus.done) begin
                    state_d = bus.dly ? WAIT : FREE;
                    hold_d  = hold_inc;
                end else if (wd_hit) begin
                    state_d   = FREE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_inc;
                end
            end
            WAIT: begin
                if (!bus.dly) begin
                    state_d = FREE;
                end else if (wd_hit) begin
                    state_d   = FREE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_inc;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Moore output decode from registered state and owner.
    always_comb begin
        tenure = (state_q == BUSY) || (state_q == WAIT);
        gnt_d  = '0;
        if (tenure) begin
            gnt_d[owner_q] = 1'b1;
        end
    end

    assign bus.gnt     = gnt_d;
    assign bus.gnt_id  = owner_q;
    assign bus.busy    = tenure;
    assign bus.timeout = timeout_q;
endmodule

// File: doc/bus_arb_fsm.md
Name: bus_arb_fsm

Overview:
- Parametrised successor of the single-master bus FSM (IDLE/BUSY/WAIT/FREE handshake on req/done/dly).
- Arbitrates NREQ requesters for one shared bus using round-robin.
- Grants one master at a time and holds the grant through the busy and wait phases.
- Adds a hold-time watchdog that forcibly reclaims the bus.
- Sits between bus masters and the shared bus mux; gnt_id drives the mux select.

Parameters:
- NREQ, 4, number of requesters (2..16).
- MAX_HOLD, 64, maximum cycles a grant may stay in BUSY+WAIT before forced release; 0 disables the watchdog.
- IDW, $clog2(NREQ), width of gnt_id (derived, not overridden).
- CW, $clog2(MAX_HOLD+1) (min 1), hold counter width (derived).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-master bus request, level.
- done  in  1  current owner finished transfer.
- dly  in  1  current owner needs extra wait cycles after done.
- gnt  out  NREQ  one-hot grant; all-zero when no owner.
- gnt_id  out  IDW  index of current/last owner.
- busy  out  1  high in BUSY or WAIT.
- timeout  out  1  single-cycle pulse when the watchdog forces release.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, owner=NREQ-1, hold_cnt=0, timeout=0.
  - Consequently gnt=0, gnt_id=NREQ-1, busy=0.
  - Reset mid-tenure drops gnt in the same cycle, with no FREE state.
- States: IDLE, BUSY, WAIT, FREE. gnt/busy are Moore outputs decoded from registered state and owner.
  - gnt[owner]=1 only in BUSY or WAIT.
- Round-robin pick: scan req starting at (owner+1) mod NREQ, wrapping; first set bit wins.
  - The previous owner has lowest priority.
  - First grant after reset goes to the lowest-index requester.
- IDLE:
  - |req=1 → BUSY; owner←pick; hold_cnt←0.
  - Otherwise stay in IDLE.
  - Latency: req sampled at edge N, gnt high after edge N.
- BUSY:
  - done=0 → stay; hold_cnt++.
  - done=1, dly=1 → WAIT.
  - done=1, dly=0 → FREE.
- WAIT:
  - dly=1 → stay; hold_cnt++.
  - dly=0 → FREE. done is ignored in WAIT.
- FREE: exactly one cycle with gnt=0 (bus turnaround).
  - |req=1 → BUSY with a new pick.
  - Otherwise → IDLE.
- Watchdog (MAX_HOLD>0): in BUSY/WAIT, if hold_cnt==MAX_HOLD-1 and no normal exit applies this cycle → FREE, and timeout=1 for that one cycle.
  - A normal exit (done in BUSY, !dly in WAIT) in the same cycle wins; no timeout.
  - hold_cnt saturates and never wraps.
- Owner dropping req while in BUSY/WAIT is ignored; only done/dly/watchdog end the tenure.
- New requests during a tenure never preempt the owner.
- FREE→BUSY may re-grant the same master only if no other req bit is set.
- done/dly are ignored in IDLE and FREE.
- No X propagation: the next-state default is the current state, never x.
- gnt_id holds its value in IDLE/FREE; consumers qualify it with busy.

Decomposition:
- Shared package bus_fsm_pkg:
  - state enum (IDLE=2'b00, BUSY=2'b01, WAIT=2'b10, FREE=2'b11), same encoding as the single-master FSM.
  - a clog2-based width helper.
- Sub-module rr_pick: combinational, parameter N; inputs req[N], last[IDW]; outputs idx[IDW], valid.
  - Reusable by future multi-bus arbiters.
- bus_arb_fsm contains the state, owner and hold counter registers plus output decode.

Test Plan:
- Reset mid-BUSY: NREQ=4, req=4'b0010 granted, assert rst_n=0 while BUSY → gnt=0, busy=0 immediately; after release, gnt_id=3.
- Single master, no delay: req=4'b0001, done pulsed 3 cycles after grant with dly=0 → gnt=0001 for 4 cycles, one FREE cycle with gnt=0, then IDLE.
- Delay path: owner 2, done=1 with dly=1 held 5 cycles → state WAIT for 5 cycles with gnt=0100; FREE after dly falls.
- Round-robin fairness: req=4'b1111 held; each tenure ends with done=1, dly=0 → grant order 0,1,2,3,0, one FREE cycle between each.
- Watchdog: MAX_HOLD=8, req=4'b0100, done never asserted → gnt=0100 for exactly 8 cycles, timeout=1 on the BUSY→FREE cycle, then re-grant to master 2 if it is the only requester.
- Done and timeout collide: done=1 on the cycle where hold_cnt==MAX_HOLD-1 → FREE with timeout=0.
